// File: rtl/fir_ctrl_if.sv
// rtl/fir_ctrl_if.sv - coefficient, sample and result stream handshakes for fir_ctrl
interface fir_ctrl_if;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] r_data;

    modport master (
        output w_valid, w_data, s_valid, s_data, r_ready,
        input  w_ready, s_ready, r_valid, r_data
    );

    modport slave (
        input  w_valid, w_data, s_valid, s_data, r_ready,
        output w_ready, s_ready, r_valid, r_data
    );
endinterface

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - sequencer feeding coefficients/samples into a 16-tap FIR (optional FIR_CTRL_WARMUP_EN)
module fir_ctrl #(
    parameter int TAPS    = 16,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start_i,
    fir_ctrl_if.slave   bus,
    output logic        fir_wind_o,
    output logic        fir_load_o,
    output logic        fir_in_valid_o,
    output logic [15:0] fir_data_o,
    input  logic        fir_out_valid_i,
    input  logic [15:0] fir_out_i,
    output logic        busy_o,
    output logic        coeff_ok_o,
    output logic        err_timeout_o
);
    localparam int WCW = $clog2(TAPS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(TAPS - 1);
    localparam logic [TCW-1:0] T_MAX  = TCW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_READY, S_KICK, S_WAIT, S_OUT
    } state_t;

    state_t         state_q;
    logic [WCW-1:0] w_cnt_q;
    logic [TCW-1:0] t_cnt_q;
    logic           r_valid_q;
    logic [15:0]    r_data_q;
    logic           coeff_ok_q;
    logic           err_timeout_q;
`ifdef FIR_CTRL_WARMUP_EN
    logic [WCW-1:0] warm_q;
    logic           drop_q;
`endif

    logic w_acc;
    logic s_acc;

    // cfg_start in READY takes priority over a pending sample
    assign bus.w_ready    = (state_q == S_WLOAD);
    assign bus.s_ready    = (state_q == S_READY) && !cfg_start_i;
    assign w_acc          = bus.w_ready && bus.w_valid;
    assign s_acc          = bus.s_ready && bus.s_valid;
    assign fir_wind_o     = w_acc;
    assign fir_load_o     = s_acc;
    assign fir_in_valid_o = (state_q == S_KICK);
    assign fir_data_o     = (state_q == S_WLOAD) ? bus.w_data : bus.s_data;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_READY);
    assign bus.r_valid    = r_valid_q;
    assign bus.r_data     = r_data_q;
    assign coeff_ok_o     = coeff_ok_q;
    assign err_timeout_o  = err_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            w_cnt_q       <= '0;
            t_cnt_q       <= '0;
            r_valid_q     <= 1'b0;
            r_data_q      <= '0;
            coeff_ok_q    <= 1'b0;
            err_timeout_q <= 1'b0;
`ifdef FIR_CTRL_WARMUP_EN
            warm_q        <= '0;
            drop_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_READY: begin
                    if (cfg_start_i) begin
                        state_q       <= S_WLOAD;
                        w_cnt_q       <= '0;
                        coeff_ok_q    <= 1'b0;
                        err_timeout_q <= 1'b0;
`ifdef FIR_CTRL_WARMUP_EN
                        warm_q        <= '0;
`endif
                    end else if (s_acc) begin
                        state_q <= S_KICK;
`ifdef FIR_CTRL_WARMUP_EN
                        // the first TAPS-1 results see a partially filled delay line
                        drop_q <= (warm_q < W_LAST);
                        if (warm_q < W_LAST) begin
                            warm_q <= warm_q + 1'b1;
                        end
`endif
                    end
                end
                S_WLOAD: begin
                    if (w_acc) begin
                        if (w_cnt_q == W_LAST) begin
                            state_q    <= S_READY;
                            coeff_ok_q <= 1'b1;
                            w_cnt_q    <= '0;
                        end else begin
                            w_cnt_q <= w_cnt_q + 1'b1;
                        end
                    end
                end
                S_KICK: begin
                    t_cnt_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fir_out_valid_i) begin
`ifdef FIR_CTRL_WARMUP_EN
                        if (drop_q) begin
                            state_q <= S_READY;
                        end else begin
                            r_data_q  <= fir_out_i;
                            r_valid_q <= 1'b1;
                            state_q   <= S_OUT;
                        end
`else
                        r_data_q  <= fir_out_i;
                        r_valid_q <= 1'b1;
                        state_q   <= S_OUT;
`endif
                    end else if (t_cnt_q == T_MAX) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_READY;
                    end else begin
                        t_cnt_q <= t_cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.r_ready) begin
                        r_valid_q <= 1'b0;
                        state_q   <= S_READY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
